// File: rtl/box_pkg.sv
// Shared definitions for the box plotter: FSM states, default geometry and
// the fill/outline mode encoding.
package box_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_XW   = 8;
  localparam int DEF_YW   = 7;
  localparam int DEF_COLW = 3;
  localparam int DEF_XMAX = 159;
  localparam int DEF_YMAX = 119;

  localparam logic MODE_FILL    = 1'b1;
  localparam logic MODE_OUTLINE = 1'b0;

endpackage

// File: rtl/box_coord_sort.sv
// Orders the two corners of a box (unsigned) and clamps the result to the
// visible screen so the scan counters can never step past the last column/row.
module box_coord_sort #(
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int XMAX = 159,
  parameter int YMAX = 119
) (
  input  logic [XW-1:0] x0_i,
  input  logic [XW-1:0] x1_i,
  input  logic [YW-1:0] y0_i,
  input  logic [YW-1:0] y1_i,
  output logic [XW-1:0] xl_o,
  output logic [XW-1:0] xr_o,
  output logic [YW-1:0] yt_o,
  output logic [YW-1:0] yb_o
);

  localparam logic [XW-1:0] XLIM = XW'(XMAX);
  localparam logic [YW-1:0] YLIM = YW'(YMAX);

  logic [XW-1:0] x_lo, x_hi;
  logic [YW-1:0] y_lo, y_hi;

  always_comb begin
    x_lo = (x0_i < x1_i) ? x0_i : x1_i;
    x_hi = (x0_i < x1_i) ? x1_i : x0_i;
    y_lo = (y0_i < y1_i) ? y0_i : y1_i;
    y_hi = (y0_i < y1_i) ? y1_i : y0_i;
    xl_o = (x_lo > XLIM) ? XLIM : x_lo;
    xr_o = (x_hi > XLIM) ? XLIM : x_hi;
    yt_o = (y_lo > YLIM) ? YLIM : y_lo;
    yb_o = (y_hi > YLIM) ? YLIM : y_hi;
  end

endmodule

// File: rtl/box_plotter.sv
// Rasterises a filled or outlined box into one pixel write per cycle for a
// vga_adapter-style frame buffer interface.
module box_plotter
  import box_pkg::*;
#(
  parameter int XW   = DEF_XW,
  parameter int YW   = DEF_YW,
  parameter int COLW = DEF_COLW,
  parameter int XMAX = DEF_XMAX,
  parameter int YMAX = DEF_YMAX
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XW-1:0]   req_x0,
  input  logic [XW-1:0]   req_x1,
  input  logic [YW-1:0]   req_y0,
  input  logic [YW-1:0]   req_y1,
  input  logic [COLW-1:0] req_col,
  input  logic            req_fill,
  input  logic            abort,
  output logic [XW-1:0]   x_out,
  output logic [YW-1:0]   y_out,
  output logic [COLW-1:0] col_out,
  output logic            plot,
  output logic            busy,
  output logic            done
);

  state_e state_q, state_d;
  logic [XW-1:0]   x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0]   y0_q, y0_d, y1_q, y1_d;
  logic [COLW-1:0] col_q, col_d, colo_q, colo_d;
  logic            fill_q, fill_d;
  logic [XW-1:0]   xl_q, xl_d, xr_q, xr_d, x_q, x_d;
  logic [YW-1:0]   yt_q, yt_d, yb_q, yb_d, y_q, y_d;
  logic [XW-1:0]   xl_s, xr_s;
  logic [YW-1:0]   yt_s, yb_s;
  logic            full_row;

  box_coord_sort #(
    .XW(XW), .YW(YW), .XMAX(XMAX), .YMAX(YMAX)
  ) u_sort (
    .x0_i(x0_q), .x1_i(x1_q), .y0_i(y0_q), .y1_i(y1_q),
    .xl_o(xl_s), .xr_o(xr_s), .yt_o(yt_s), .yb_o(yb_s)
  );

  // Interior outline rows jump straight from xl to xr.
  assign full_row = (fill_q == MODE_FILL) || (y_q == yt_q) || (y_q == yb_q);

  always_comb begin
    state_d = state_q;
    x0_d = x0_q;  x1_d = x1_q;  y0_d = y0_q;  y1_d = y1_q;
    col_d = col_q;  fill_d = fill_q;  colo_d = colo_q;
    xl_d = xl_q;  xr_d = xr_q;  yt_d = yt_q;  yb_d = yb_q;
    x_d = x_q;  y_d = y_q;
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          x0_d = req_x0;  x1_d = req_x1;  y0_d = req_y0;  y1_d = req_y1;
          col_d = req_col;  fill_d = req_fill;
          state_d = SETUP;
        end
        SETUP: begin
          xl_d = xl_s;  xr_d = xr_s;  yt_d = yt_s;  yb_d = yb_s;
          x_d = xl_s;  y_d = yt_s;  colo_d = col_q;
          state_d = SCAN;
        end
        SCAN: begin
          if (x_q != xr_q) begin
            x_d = full_row ? x_q + 1'b1 : xr_q;
          end else if (y_q == yb_q) begin
            state_d = DONE;
          end else begin
            x_d = xl_q;
            y_d = y_q + 1'b1;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      x0_q <= '0;  x1_q <= '0;  y0_q <= '0;  y1_q <= '0;
      col_q <= '0;  fill_q <= 1'b0;  colo_q <= '0;
      xl_q <= '0;  xr_q <= '0;  yt_q <= '0;  yb_q <= '0;
      x_q <= '0;  y_q <= '0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;  x1_q <= x1_d;  y0_q <= y0_d;  y1_q <= y1_d;
      col_q <= col_d;  fill_q <= fill_d;  colo_q <= colo_d;
      xl_q <= xl_d;  xr_q <= xr_d;  yt_q <= yt_d;  yb_q <= yb_d;
      x_q <= x_d;  y_q <= y_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign plot      = (state_q == SCAN) && !abort;
  assign done      = (state_q == DONE) && !abort;
  assign x_out     = x_q;
  assign y_out     = y_q;
  assign col_out   = colo_q;

endmodule

// File: doc/box_plotter.md
BOX_PLOTTER -- requirements
Module: box_plotter

Interface
REQ-001 The module SHALL have parameter XW, default 8, meaning x coordinate width.
REQ-002 The module SHALL have parameter YW, default 7, meaning y coordinate width.
REQ-003 The module SHALL have parameter COLW, default 3, meaning colour width.
REQ-004 The module SHALL have parameter XMAX, default 159, meaning the largest legal x.
REQ-005 The module SHALL have parameter YMAX, default 119, meaning the largest legal y.
REQ-006 Ports SHALL be, one per line:
- clk  in  1  sole clock.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  box request present.
- req_ready  out  1  request accepted when both req_valid and req_ready are high.
- req_x0, req_x1  in  XW  corner x values, unordered.
- req_y0, req_y1  in  YW  corner y values, unordered.
- req_col  in  COLW  pixel colour.
- req_fill  in  1  1 = filled box, 0 = outline only.
- abort  in  1  abandon the current box.
- x_out  out  XW  pixel x to the vga_adapter.
- y_out  out  YW  pixel y to the vga_adapter.
- col_out  out  COLW  pixel colour.
- plot  out  1  pixel write strobe.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle completion pulse.

Function
REQ-007 The FSM SHALL have states IDLE, SETUP, SCAN and DONE; req_ready SHALL be high only in IDLE.
REQ-008 On accept, the module SHALL register the request and go to SETUP; later changes on req_* SHALL be ignored until the next accept.
REQ-009 SETUP SHALL take one cycle: xl=min(x0,x1), xr=max(x0,x1), yt=min(y0,y1), yb=max(y0,y1), each clamped to XMAX/YMAX; compares SHALL be unsigned.
REQ-010 The first plot SHALL occur 2 cycles after the accept cycle: accept at N, SETUP at N+1, first pixel (xl,yt) at N+2.
REQ-011 SCAN SHALL emit exactly one pixel per cycle with plot=1, in raster order: x increments to xr, then x returns to xl and y increments.
REQ-012 In fill mode, SCAN SHALL emit every pixel in [xl..xr]x[yt..yb], taking W*H cycles, where W=xr-xl+1 and H=yb-yt+1.
REQ-013 In outline mode, rows yt and yb SHALL be emitted in full; each interior row SHALL emit only xl then xr on consecutive cycles, or xl alone if W==1.
REQ-014 Outline cycle count SHALL be W*H if H<=2, H if W==1, and 2W+2(H-2) otherwise; no pixel SHALL be emitted twice.
REQ-015 After the last pixel, the FSM SHALL enter DONE for one cycle with done=1 and plot=0, then return to IDLE.
REQ-016 When plot=0, x_out, y_out and col_out SHALL hold their last values.
REQ-017 Degenerate boxes SHALL be legal: x0==x1 and y0==y1 gives exactly one pixel.
REQ-018 abort=1 in SETUP, SCAN or DONE SHALL force IDLE on the next edge, with plot=0 and done=0 that cycle; abort in IDLE SHALL be ignored.
REQ-019 If abort and req_valid are high together in IDLE, the request SHALL be accepted.
REQ-020 Internal counters SHALL be XW and YW wide; clamping SHALL ensure the row/column increment never wraps.

Reset
REQ-021 While resetn=0: state SHALL be IDLE; plot, done and busy SHALL be 0; req_ready SHALL be 1; x_out, y_out and col_out SHALL be 0.
REQ-022 Reset asserted mid-SCAN SHALL stop plotting immediately (asynchronously); no done SHALL follow.

Structure
REQ-023 Package box_pkg SHALL hold the state enumeration, the default XW/YW/COLW/XMAX/YMAX constants, and the mode encoding (FILL=1, OUTLINE=0).
REQ-024 The sort and clamp logic of REQ-009 SHALL be a combinational sub-module, box_coord_sort, instantiated once; all other logic SHALL be in box_plotter.

Verification
REQ-025 Fill box (x0=10,x1=12,y0=5,y1=6): 6 plots at cycles N+2..N+7, order (10,5)(11,5)(12,5)(10,6)(11,6)(12,6), done at N+8.
REQ-026 Outline box (x0=20,x1=16,y0=40,y1=36): corners are swapped; exactly 16 plots; interior rows emit only x=16 and x=20; no duplicate coordinates.
REQ-027 Clamp (x0=150,x1=200,y0=118,y1=127, fill): only x 150..159 and y 118..119 are plotted; 20 plots total.
REQ-028 Single pixel (7,7,3,3): one plot at (7,3) at N+2, done at N+3; back-to-back request accepted at N+4.
REQ-029 Abort at the 3rd SCAN cycle of a 4x4 fill: plot is 0 the next cycle, no done, req_ready=1; resetn pulsed low mid-SCAN makes plot and busy 0 immediately.
